serial_bus_master_param: RTL
============================

// Module: serial_bus_master_param
// PURPOSE
//  Parametrised serial bus master. It latches an address and data word from the user
//  and runs a read or write on the shared serial bus.
//  - Slave-select bits are shifted first; the rest of the address (and data) follows
//    once the arbiter re-grants the bus.
//  - If the grant is lost mid-transfer, the transfer is retried from the start.
//  - Reads are bounded by a slave-response timeout and end with a done/error status.
// PARAMETERS
//  ADDR_W      14    address width, shifted MSB first on addr_tx
//  DATA_W      8     data width, MSB first; constraint DATA_W <= ADDR_W-SEL_W
//  SEL_W       2     leading address bits that select the slave (sent before the regrant wait)
//  RESP_TMO    1023  max cycles to wait for slave_valid on a read
//  MAX_RETRY   3     grant-loss retries allowed before error
// PORTS
//  clock           in   1       system clock, all logic on posedge
//  reset           in   1       synchronous, active-high
//  enable          in   1       user request; acted on at its rising edge only
//  read_en         in   1       1=read, 0=write; sampled with enable
//  data_in         in   DATA_W  write data
//  addr_in         in   ADDR_W  target address
//  data_rx         in   1       serial read data from slave
//  slave_ready     in   1       slave can accept a transaction; checked in REQ
//  bus_ready       in   1       arbiter grant (level)
//  slave_valid     in   1       slave starts driving read data next cycle
//  bus_req         out  1       bus request to arbiter
//  addr_tx         out  1       serial address
//  data_tx         out  1       serial write data
//  valid           out  1       request-valid to arbiter
//  valid_s         out  1       frame-valid to slave
//  write_en_slave  out  1       1=write, 0=read; held for the whole transaction
//  master_busy     out  1       high from accept until return to IDLE
//  data_read       out  DATA_W  last completed read word; updated only on a good read
//  done            out  1       1-cycle pulse on successful completion
//  error           out  1       1-cycle pulse on timeout or retry overflow
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, counters and buffers 0.
//  Accept rule: in IDLE, a rising edge of enable (enable=1, previous cycle 0) latches
//   addr_in, data_in and read_en, and sets master_busy=1, bus_req=1, valid=1.
//  Ignored inputs: enable while busy is ignored; a new edge is needed after IDLE.
//  States and transitions:
//   IDLE -> REQ on accept.
//   REQ: hold bus_req and valid until bus_ready=1 and slave_ready=1, then SEL.
//    write_en_slave=~read_en is valid from REQ onward. valid drops on the exit edge.
//   SEL: valid_s=1; shift SEL_W select bits on addr_tx, one per cycle. Then WAIT.
//   WAIT: valid_s=0; wait for bus_ready=1 (slave-path grant). Then XFER.
//   XFER: valid_s=1; shift the remaining ADDR_W-SEL_W address bits.
//    On write, data_tx carries data bit k alongside the last DATA_W address bits.
//    Write path: valid_s drops the cycle after the last bit; done pulses; -> IDLE.
//    Read path: -> RESP after the last address bit.
//   RESP: valid_s=0; count cycles.
//    slave_valid=1 -> RX.
//    Count reaching RESP_TMO -> error pulse, -> IDLE; data_read unchanged.
//   RX: sample data_rx for DATA_W cycles, MSB first.
//    data_read is loaded with the full word in one cycle; done pulses; -> IDLE.
//  Grant loss: bus_ready=0 during SEL or XFER causes an abort.
//   Outputs during abort: addr_tx, data_tx and valid_s go to 0 next cycle.
//   Retry path: retry_cnt increments; shift registers reload from the latched buffers;
//    -> REQ, restarting from the first select bit.
//   Overflow: if retry_cnt would exceed MAX_RETRY, error pulses and -> IDLE.
//  Write latency: with grants always high, the frame takes 2+SEL_W+1+(ADDR_W-SEL_W)
//   cycles from accept to done.
//  Simultaneous events: bus_ready fall and the last XFER bit in the same cycle counts as
//   an abort. done and error are mutually exclusive.
//  Reset mid-operation: immediate return to IDLE; all outputs 0; no done or error.
//  Width rules: counters are $clog2(ADDR_W+1) bits; the timeout counter is
//   $clog2(RESP_TMO+1) bits; both saturate and never wrap.
// STRUCTURE
//  Package serial_bus_pkg: state encoding localparams; default ADDR_W/DATA_W/SEL_W;
//   the DATA_W <= ADDR_W-SEL_W check function.
//  Sub-module serial_shifter: parametrised-width PISO/SIPO with load, shift and clear.
//   Instantiated for addr_tx, data_tx and the data_rx capture.
// TESTING (ADDR_W=14, DATA_W=8, SEL_W=2)
//  Write, grants high: addr 0x2A5C, data 0xC3.
//   -> addr_tx = 10 1010 0101 1100; data_tx = 11000011 on the last 8 address bits;
//      done at accept+17; write_en_slave=1 throughout.
//  Read: addr 0x1FFF; slave_valid 5 cycles after the last address bit; data_rx=10110010.
//   -> data_read=0xB2; one done pulse.
//  Read timeout: slave_valid never asserted.
//   -> error at RESP entry+1023; data_read keeps its previous 0xB2; master_busy falls.
//  Grant loss: drop bus_ready for 3 cycles at XFER bit 6.
//   -> abort, REQ, full retransmit; done once. Four drops -> error after the 4th.
//  enable held high across two transactions -> only one accepted.
//   reset at XFER bit 4 -> all outputs 0 next cycle; no done or error.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// rtl/serial_bus_pkg.sv - shared defaults, state encoding and width check for the serial bus master
package serial_bus_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_SEL_W  = 2;
    localparam int STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_SEL  = 3'd2,
        ST_WAIT = 3'd3,
        ST_XFER = 3'd4,
        ST_RESP = 3'd5,
        ST_RX   = 3'd6
    } state_t;

    // Write data rides on the tail of the post-select address bits, so it must fit there.
    function automatic bit widths_ok(input int addr_w, input int data_w, input int sel_w);
        return (sel_w >= 1) && (sel_w < addr_w) && (data_w >= 1) && (data_w <= addr_w - sel_w);
    endfunction

endpackage

// File: rtl/serial_bus_master_param_if.sv
// rtl/serial_bus_master_param_if.sv - user request and serial bus signals of the bus master
interface serial_bus_master_param_if
    import serial_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              enable;
    logic              read_en;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] addr_in;
    logic              data_rx;
    logic              slave_ready;
    logic              bus_ready;
    logic              slave_valid;

    logic              bus_req;
    logic              addr_tx;
    logic              data_tx;
    logic              valid;
    logic              valid_s;
    logic              write_en_slave;
    logic              master_busy;
    logic [DATA_W-1:0] data_read;
    logic              done;
    logic              error;

    modport master (
        input  enable, read_en, data_in, addr_in, data_rx, slave_ready, bus_ready, slave_valid,
        output bus_req, addr_tx, data_tx, valid, valid_s, write_en_slave, master_busy,
               data_read, done, error
    );

    modport slave (
        output enable, read_en, data_in, addr_in, data_rx, slave_ready, bus_ready, slave_valid,
        input  bus_req, addr_tx, data_tx, valid, valid_s, write_en_slave, master_busy,
               data_read, done, error
    );

endinterface

// File: rtl/serial_shifter.sv
// rtl/serial_shifter.sv - parallel/serial shift register, MSB out first, with load, shift and clear
module serial_shifter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         shift,
    input  logic         ser_in,
    input  logic [W-1:0] load_val,
    output logic         ser_out,
    output logic [W-1:0] par_out
);

    logic [W-1:0] sr;
    logic [W-1:0] shifted;

    always_comb begin
        shifted    = '0;
        shifted[0] = ser_in;
        for (int i = 1; i < W; i++) begin
            shifted[i] = sr[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_val;
        end else if (shift) begin
            sr <= shifted;
        end
    end

    assign ser_out = sr[W-1];
    assign par_out = sr;

endmodule

// File: rtl/serial_bus_master_param.sv
// rtl/serial_bus_master_param.sv - serial bus master: select bits, regrant, address/data, read response
module serial_bus_master_param
    import serial_bus_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SEL_W     = DEF_SEL_W,
    parameter int RESP_TMO  = 1023,
    parameter int MAX_RETRY = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    serial_bus_master_param_if.master  bus
);

    localparam int XFER_W = ADDR_W - SEL_W;
    localparam int CNT_W  = $clog2(ADDR_W + 1);
    localparam int TMO_W  = $clog2(RESP_TMO + 1);

    localparam logic [CNT_W-1:0] SEL_LAST  = CNT_W'(SEL_W);
    localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(XFER_W);
    localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] RETRY_MAX = CNT_W'(MAX_RETRY);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(RESP_TMO - 1);

    if (!widths_ok(ADDR_W, DATA_W, SEL_W)) begin : g_cfg_err
        $error("serial_bus_master_param: DATA_W must not exceed ADDR_W-SEL_W");
    end

    state_t             state;
    logic               enable_q;
    logic [ADDR_W-1:0]  addr_buf;
    logic [DATA_W-1:0]  data_buf;
    logic               rd_buf;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   retry_cnt;
    logic [TMO_W-1:0]   tmo_cnt;

    logic               accept;
    logic               abort;
    logic               emit_addr;
    logic               emit_data;
    logic               asr_ser;
    logic               dsr_ser;
    logic               rsr_ser;
    logic [ADDR_W-1:0]  asr_par;
    logic [XFER_W-1:0]  dsr_par;
    logic [DATA_W-1:0]  rsr_par;
    logic [DATA_W:0]    rx_ext;

    always_comb begin
        accept    = (state == ST_IDLE) && bus.enable && !enable_q;
        abort     = ((state == ST_SEL) || (state == ST_XFER)) && !bus.bus_ready;
        emit_addr = 1'b0;
        emit_data = 1'b0;
        case (state)
            ST_REQ:  emit_addr = bus.bus_ready && bus.slave_ready;
            ST_SEL:  emit_addr = bus.bus_ready && (bit_cnt != SEL_LAST);
            ST_WAIT: begin
                emit_addr = bus.bus_ready;
                emit_data = bus.bus_ready;
            end
            ST_XFER: begin
                emit_addr = bus.bus_ready && (bit_cnt != XFER_LAST);
                emit_data = bus.bus_ready && (bit_cnt != XFER_LAST);
            end
            default: ;
        endcase
    end

    // Shifters load straight from the user inputs on accept and from the latched copies on a retry.
    serial_shifter #(.W(ADDR_W)) u_addr_sr (
        .clock    (clock),
        .reset    (reset),
        .clear    (1'b0),
        .load     (accept || abort),
        .shift    (emit_addr),
        .ser_in   (1'b0),
        .load_val (accept ? bus.addr_in : addr_buf),
        .ser_out  (asr_ser),
        .par_out  (asr_par)
    );

    // Data is right-aligned so its MSB lines up with address bit DATA_W-1.
    serial_shifter #(.W(XFER_W)) u_data_sr (
        .clock    (clock),
        .reset    (reset),
        .clear    (1'b0),
        .load     (accept || abort),
        .shift    (emit_data),
        .ser_in   (1'b0),
        .load_val (XFER_W'(accept ? bus.data_in : data_buf)),
        .ser_out  (dsr_ser),
        .par_out  (dsr_par)
    );

    serial_shifter #(.W(DATA_W)) u_rx_sr (
        .clock    (clock),
        .reset    (reset),
        .clear    (accept),
        .load     (1'b0),
        .shift    (state == ST_RX),
        .ser_in   (bus.data_rx),
        .load_val ('0),
        .ser_out  (rsr_ser),
        .par_out  (rsr_par)
    );

    assign rx_ext = {rsr_par, bus.data_rx};

    logic unused_bits;
    assign unused_bits = ^{asr_par, dsr_par, rsr_ser, rx_ext[DATA_W]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= ST_IDLE;
            enable_q           <= 1'b0;
            addr_buf           <= '0;
            data_buf           <= '0;
            rd_buf             <= 1'b0;
            bit_cnt            <= '0;
            retry_cnt          <= '0;
            tmo_cnt            <= '0;
            bus.bus_req        <= 1'b0;
            bus.addr_tx        <= 1'b0;
            bus.data_tx        <= 1'b0;
            bus.valid          <= 1'b0;
            bus.valid_s        <= 1'b0;
            bus.write_en_slave <= 1'b0;
            bus.master_busy    <= 1'b0;
            bus.data_read      <= '0;
            bus.done           <= 1'b0;
            bus.error          <= 1'b0;
        end else begin
            enable_q  <= bus.enable;
            bus.done  <= 1'b0;
            bus.error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_buf           <= bus.addr_in;
                        data_buf           <= bus.data_in;
                        rd_buf             <= bus.read_en;
                        retry_cnt          <= '0;
                        bus.write_en_slave <= ~bus.read_en;
                        bus.master_busy    <= 1'b1;
                        bus.bus_req        <= 1'b1;
                        bus.valid          <= 1'b1;
                        state              <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.bus_ready && bus.slave_ready) begin
                        bus.valid   <= 1'b0;
                        bus.valid_s <= 1'b1;
                        bus.addr_tx <= asr_ser;
                        bit_cnt     <= CNT_W'(1);
                        state       <= ST_SEL;
                    end
                end
                ST_SEL, ST_XFER: begin
                    if (abort) begin
                        bus.addr_tx <= 1'b0;
                        bus.data_tx <= 1'b0;
                        bus.valid_s <= 1'b0;
                        if (retry_cnt >= RETRY_MAX) begin
                            bus.error          <= 1'b1;
                            bus.master_busy    <= 1'b0;
                            bus.bus_req        <= 1'b0;
                            bus.valid          <= 1'b0;
                            bus.write_en_slave <= 1'b0;
                            state              <= ST_IDLE;
                        end else begin
                            retry_cnt <= retry_cnt + 1'b1;
                            bus.valid <= 1'b1;
                            state     <= ST_REQ;
                        end
                    end else if (emit_addr) begin
                        bus.addr_tx <= asr_ser;
                        bus.data_tx <= (state == ST_XFER) && !rd_buf && dsr_ser;
                        bit_cnt     <= (bit_cnt == '1) ? bit_cnt : bit_cnt + 1'b1;
                    end else if (state == ST_SEL) begin
                        bus.valid_s <= 1'b0;
                        bus.addr_tx <= 1'b0;
                        state       <= ST_WAIT;
                    end else begin
                        bus.valid_s <= 1'b0;
                        bus.addr_tx <= 1'b0;
                        bus.data_tx <= 1'b0;
                        if (rd_buf) begin
                            tmo_cnt <= '0;
                            state   <= ST_RESP;
                        end else begin
                            bus.done           <= 1'b1;
                            bus.master_busy    <= 1'b0;
                            bus.bus_req        <= 1'b0;
                            bus.write_en_slave <= 1'b0;
                            state              <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.bus_ready) begin
                        bus.valid_s <= 1'b1;
                        bus.addr_tx <= asr_ser;
                        bus.data_tx <= !rd_buf && dsr_ser;
                        bit_cnt     <= CNT_W'(1);
                        state       <= ST_XFER;
                    end
                end
                ST_RESP: begin
                    if (bus.slave_valid) begin
                        bit_cnt <= '0;
                        state   <= ST_RX;
                    end else if (tmo_cnt >= TMO_LAST) begin
                        bus.error       <= 1'b1;
                        bus.master_busy <= 1'b0;
                        bus.bus_req     <= 1'b0;
                        state           <= ST_IDLE;
                    end else begin
                        tmo_cnt <= (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
                    end
                end
                ST_RX: begin
                    if (bit_cnt == RX_LAST) begin
                        bus.data_read   <= rx_ext[DATA_W-1:0];
                        bus.done        <= 1'b1;
                        bus.master_busy <= 1'b0;
                        bus.bus_req     <= 1'b0;
                        state           <= ST_IDLE;
                    end else begin
                        bit_cnt <= (bit_cnt == '1) ? bit_cnt : bit_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
